// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer sequencing FSM.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    RUN   = 3'd2,
    CMP   = 3'd3,
    SCORE = 3'd4,
    HISC  = 3'd5,
    FOUL  = 3'd6
  } state_t;

  localparam logic [1:0] DISP_BLANK   = 2'd0;
  localparam logic [1:0] DISP_LIVE    = 2'd1;
  localparam logic [1:0] DISP_SCORE   = 2'd2;
  localparam logic [1:0] DISP_HISCORE = 2'd3;

  localparam logic [9:0] LED_OFF    = 10'h000;
  localparam logic [9:0] LED_ALL    = 10'h3FF;
  localparam logic [9:0] LED_RECORD = 10'b1010101010;
  localparam logic [9:0] LED_FOUL   = 10'b0101010101;

  localparam logic [15:0] HISCORE_NONE = 16'hFFFF;
  localparam logic [15:0] BCD_MAX      = 16'h9999;

endpackage

// File: rtl/ms_delay_timer.sv
// Loadable down-counter stepped by the 1 ms tick; done fires combinationally on
// the tick that takes the count from 1 to 0 so the FSM can leave WAIT on that edge.
module ms_delay_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  input  logic         tick,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (en && tick && count != '0)
      count <= count - W'(1);
  end

  assign done = en && tick && (count == W'(1));

endmodule

// File: rtl/reaction_controller.sv
// Reaction-timer game sequencer: arms the LFSR, runs the random wait, times the player and
// tracks the best score. Optional false-start detection is enabled with `define FALSE_START_EN.
module reaction_controller
  import reaction_pkg::*;
#(
  parameter int DELAY_W   = 11,
  parameter int MIN_DELAY = 500
) (
  input  logic               MAX10_CLK1_50,
  input  logic               reset,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               ms_tick_i,
  input  logic [DELAY_W-1:0] rand_i,
  input  logic [15:0]        elapsed_i,
  output logic               lfsr_en_o,
  output logic               cnt_clr_o,
  output logic               cnt_en_o,
  output logic [15:0]        score_o,
  output logic [15:0]        hiscore_o,
  output logic               new_hi_o,
  output logic [1:0]         disp_sel_o,
  output logic [9:0]         led_o,
  output logic [2:0]         state_o
);

  localparam logic [DELAY_W-1:0] MIN_D = DELAY_W'(MIN_DELAY);

  state_t             state, next_state;
  logic               round_start, is_record, timer_done;
  logic               next_lfsr_en, next_cnt_en, next_new_hi;
  logic [1:0]         next_disp;
  logic [9:0]         next_led;
  logic [DELAY_W-1:0] delay_load;

  assign delay_load = (rand_i < MIN_D) ? MIN_D : rand_i;
  assign is_record  = (score_o < hiscore_o);
  assign state_o    = state;

  ms_delay_timer #(.W(DELAY_W)) u_delay (
    .clk        (MAX10_CLK1_50),
    .reset      (reset),
    .load       (round_start),
    .load_value (delay_load),
    .en         (state == WAIT),
    .tick       (ms_tick_i),
    .done       (timer_done)
  );

  // Outputs are decoded from next_state so they register on the same edge as the state.
  always_comb begin
    next_state  = state;
    round_start = 1'b0;
    case (state)
      IDLE:  if (start_i) round_start = 1'b1;
      WAIT: begin
`ifdef FALSE_START_EN
        if (stop_i) next_state = FOUL;
        else
`endif
        if (timer_done) next_state = RUN;
      end
      RUN:   if (stop_i || elapsed_i == BCD_MAX) next_state = CMP;
      CMP:   next_state = SCORE;
      SCORE: if (start_i) round_start = 1'b1; else if (stop_i) next_state = HISC;
      HISC:  if (start_i) round_start = 1'b1; else if (stop_i) next_state = SCORE;
      FOUL:  if (start_i) round_start = 1'b1;
      default: next_state = IDLE;
    endcase
    if (round_start) next_state = WAIT;

    next_new_hi = new_hi_o;
    if (round_start) next_new_hi = 1'b0;
    else if (state == CMP && is_record) next_new_hi = 1'b1;

    next_lfsr_en = 1'b0;
    next_cnt_en  = 1'b0;
    next_disp    = DISP_BLANK;
    next_led     = LED_OFF;
    case (next_state)
      IDLE: next_lfsr_en = 1'b1;
      RUN: begin
        next_cnt_en = 1'b1;
        next_disp   = DISP_LIVE;
        next_led    = LED_ALL;
      end
      // Hold the frozen live value for the single compare cycle.
      CMP: begin
        next_disp = DISP_LIVE;
        next_led  = LED_ALL;
      end
      SCORE: begin
        next_disp = DISP_SCORE;
        next_led  = next_new_hi ? LED_RECORD : LED_OFF;
      end
      HISC: begin
        next_disp = DISP_HISCORE;
        next_led  = next_new_hi ? LED_RECORD : LED_OFF;
      end
      FOUL: begin
        next_lfsr_en = 1'b1;
        next_led     = LED_FOUL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state      <= IDLE;
      lfsr_en_o  <= 1'b1;
      cnt_clr_o  <= 1'b0;
      cnt_en_o   <= 1'b0;
      score_o    <= '0;
      hiscore_o  <= HISCORE_NONE;
      new_hi_o   <= 1'b0;
      disp_sel_o <= DISP_BLANK;
      led_o      <= LED_OFF;
    end else begin
      state      <= next_state;
      lfsr_en_o  <= next_lfsr_en;
      cnt_clr_o  <= round_start;
      cnt_en_o   <= next_cnt_en;
      new_hi_o   <= next_new_hi;
      disp_sel_o <= next_disp;
      led_o      <= next_led;
      if (state == RUN && next_state == CMP) score_o <= elapsed_i;
      if (state == CMP && is_record) hiscore_o <= score_o;
    end
  end

endmodule

// File: tb/tb_reaction_controller.sv
// Scoreboard bench for reaction_controller: expected output snapshots are queued by the
// stimulus and popped by a monitor on every state change (or explicit probe).
module tb_reaction_controller;
  import reaction_pkg::*;

  typedef struct {
    logic [2:0]  st;
    logic        lfsr;
    logic        clr;
    logic        en;
    logic [15:0] score;
    logic [15:0] hi;
    logic        nh;
    logic [1:0]  disp;
    logic [9:0]  led;
  } snap_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0, stop_i = 1'b0, ms_tick_i = 1'b0;
  logic [10:0] rand_i = '0;
  logic [15:0] elapsed_i = '0;
  logic        lfsr_en_o, cnt_clr_o, cnt_en_o, new_hi_o;
  logic [15:0] score_o, hiscore_o;
  logic [1:0]  disp_sel_o;
  logic [9:0]  led_o;
  logic [2:0]  state_o;

  snap_t       exp_q[$];
  snap_t       mon_s;
  int          tests = 0, failures = 0, clr_pulses = 0;
  bit          probe = 1'b0;
  logic [2:0]  last_state = 3'd0;

  always #5 clk = ~clk;

  reaction_controller #(.DELAY_W(11), .MIN_DELAY(500)) dut (
    .MAX10_CLK1_50 (clk),
    .reset         (reset),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .ms_tick_i     (ms_tick_i),
    .rand_i        (rand_i),
    .elapsed_i     (elapsed_i),
    .lfsr_en_o     (lfsr_en_o),
    .cnt_clr_o     (cnt_clr_o),
    .cnt_en_o      (cnt_en_o),
    .score_o       (score_o),
    .hiscore_o     (hiscore_o),
    .new_hi_o      (new_hi_o),
    .disp_sel_o    (disp_sel_o),
    .led_o         (led_o),
    .state_o       (state_o)
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic snap_t mk(input logic [2:0] st, input logic lfsr, input logic clr,
                               input logic en, input logic [15:0] score, input logic [15:0] hi,
                               input logic nh, input logic [1:0] disp, input logic [9:0] led);
    snap_t s;
    s.st = st; s.lfsr = lfsr; s.clr = clr; s.en = en; s.score = score;
    s.hi = hi; s.nh = nh; s.disp = disp; s.led = led;
    return s;
  endfunction

  // Monitor: compares the whole output set whenever the DUT presents a new state.
  always @(negedge clk) begin
    if (cnt_clr_o) clr_pulses++;
    if (probe || (!reset && state_o != last_state)) begin
      if (exp_q.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL unexpected_transition: got state %0d, expected no change", state_o);
      end else begin
        mon_s = exp_q.pop_front();
        checkOutput("state",    16'(state_o),    16'(mon_s.st));
        checkOutput("lfsr_en",  16'(lfsr_en_o),  16'(mon_s.lfsr));
        checkOutput("cnt_clr",  16'(cnt_clr_o),  16'(mon_s.clr));
        checkOutput("cnt_en",   16'(cnt_en_o),   16'(mon_s.en));
        checkOutput("score",    score_o,         mon_s.score);
        checkOutput("hiscore",  hiscore_o,       mon_s.hi);
        checkOutput("new_hi",   16'(new_hi_o),   16'(mon_s.nh));
        checkOutput("disp_sel", 16'(disp_sel_o), 16'(mon_s.disp));
        checkOutput("led",      16'(led_o),      16'(mon_s.led));
      end
      probe = 1'b0;
    end
    last_state = state_o;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic [10:0] rnd);
    rand_i  = rnd;
    start_i = st;
    stop_i  = sp;
    step();
    start_i = 1'b0;
    stop_i  = 1'b0;
  endtask

  task automatic tick();
    ms_tick_i = 1'b1;
    step();
    ms_tick_i = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Expects only the queued RUN snapshot to be pending; RUN must appear on exactly the n-th tick.
  task automatic run_ticks(input int n);
    ticks(n - 1);
    checkOutput("no_early_run", 16'(exp_q.size()), 16'd1);
    tick();
    checkOutput("run_on_last_tick", 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    snap_t rst_snap;
    rst_snap = mk(IDLE, 1, 0, 0, 16'h0000, 16'hFFFF, 0, DISP_BLANK, LED_OFF);

    step(); step();
    exp_q.push_back(rst_snap);
    probe = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Round 1: rand below floor, delay clamps to 500; first score is a record.
    exp_q.push_back(mk(WAIT, 0, 1, 0, 16'h0000, 16'hFFFF, 0, DISP_BLANK, LED_OFF));
    applyStimulus(1, 0, 11'd20);
    exp_q.push_back(mk(RUN, 0, 0, 1, 16'h0000, 16'hFFFF, 0, DISP_LIVE, LED_ALL));
    run_ticks(500);
    checkOutput("clr_pulse_count", 16'(clr_pulses), 16'd1);
    elapsed_i = 16'h0312;
    exp_q.push_back(mk(CMP, 0, 0, 0, 16'h0312, 16'hFFFF, 0, DISP_LIVE, LED_ALL));
    exp_q.push_back(mk(SCORE, 0, 0, 0, 16'h0312, 16'h0312, 1, DISP_SCORE, LED_RECORD));
    applyStimulus(0, 1, 11'd20);
    step(); step();

    // Round 2: start and stop together in SCORE -> start wins; rand 1200 used as-is.
    exp_q.push_back(mk(WAIT, 0, 1, 0, 16'h0312, 16'h0312, 0, DISP_BLANK, LED_OFF));
    applyStimulus(1, 1, 11'd1200);
    exp_q.push_back(mk(RUN, 0, 0, 1, 16'h0312, 16'h0312, 0, DISP_LIVE, LED_ALL));
    run_ticks(1200);
    elapsed_i = 16'h0450;
    exp_q.push_back(mk(CMP, 0, 0, 0, 16'h0450, 16'h0312, 0, DISP_LIVE, LED_ALL));
    exp_q.push_back(mk(SCORE, 0, 0, 0, 16'h0450, 16'h0312, 0, DISP_SCORE, LED_OFF));
    applyStimulus(0, 1, 11'd0);
    step(); step();
    exp_q.push_back(mk(HISC, 0, 0, 0, 16'h0450, 16'h0312, 0, DISP_HISCORE, LED_OFF));
    applyStimulus(0, 1, 11'd0);
    step();
    exp_q.push_back(mk(SCORE, 0, 0, 0, 16'h0450, 16'h0312, 0, DISP_SCORE, LED_OFF));
    applyStimulus(0, 1, 11'd0);
    step();

    // Round 3: counter saturates at 9.999 s without a stop press.
    elapsed_i = 16'h0000;
    exp_q.push_back(mk(WAIT, 0, 1, 0, 16'h0450, 16'h0312, 0, DISP_BLANK, LED_OFF));
    applyStimulus(1, 0, 11'd0);
    exp_q.push_back(mk(RUN, 0, 0, 1, 16'h0450, 16'h0312, 0, DISP_LIVE, LED_ALL));
    run_ticks(500);
    exp_q.push_back(mk(CMP, 0, 0, 0, 16'h9999, 16'h0312, 0, DISP_LIVE, LED_ALL));
    exp_q.push_back(mk(SCORE, 0, 0, 0, 16'h9999, 16'h0312, 0, DISP_SCORE, LED_OFF));
    elapsed_i = 16'h9999;
    step(); step(); step();
    elapsed_i = 16'h0000;

    // Round 4: stop pressed during the wait.
    exp_q.push_back(mk(WAIT, 0, 1, 0, 16'h9999, 16'h0312, 0, DISP_BLANK, LED_OFF));
    applyStimulus(1, 0, 11'd600);
    ticks(100);
`ifdef FALSE_START_EN
    exp_q.push_back(mk(FOUL, 1, 0, 0, 16'h9999, 16'h0312, 0, DISP_BLANK, LED_FOUL));
    applyStimulus(0, 1, 11'd600);
    step(); step();
    exp_q.push_back(mk(WAIT, 0, 1, 0, 16'h9999, 16'h0312, 0, DISP_BLANK, LED_OFF));
    applyStimulus(1, 0, 11'd20);
    exp_q.push_back(mk(RUN, 0, 0, 1, 16'h9999, 16'h0312, 0, DISP_LIVE, LED_ALL));
    run_ticks(500);
`else
    applyStimulus(0, 1, 11'd600);
    exp_q.push_back(mk(RUN, 0, 0, 1, 16'h9999, 16'h0312, 0, DISP_LIVE, LED_ALL));
    run_ticks(500);
`endif

    // Reset in RUN drops everything, including the best score.
    exp_q.push_back(rst_snap);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Stop in IDLE is ignored; any transition here is flagged by the monitor.
    applyStimulus(0, 1, 11'd0);
    step(); step();
    checkOutput("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
